fir_output_quantizer: RTL and testbench

FIR_OUTPUT_QUANTIZER -- requirements
Module: fir_output_quantizer

---
 rtl/fir_output_quantizer.sv | 123 ++++++++++++
 tb/tb_fir_output_quantizer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_quantizer.sv
// FIR output quantizer: round, narrow, and buffer samples in a show-ahead FIFO.
// Define FIR_QUANT_SAT_EN to saturate out-of-range samples; otherwise they wrap.
module fir_output_quantizer #(
  parameter int IN_WIDTH  = 38,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  FIR_output,
  input  logic                 output_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] q_data,
  output logic                 q_valid,
  input  logic                 q_ready,
  output logic [15:0]          sat_count,
  output logic                 overrun,
  input  logic                 clr_stats
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic signed [IN_WIDTH:0] RND =
    (IN_WIDTH+1)'(1) << (SHIFT-1);

  logic [OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] q_data_q, q_data_d;
  logic          q_valid_q;
  logic          ovr_q, ovr_d;
  logic          push, pop;

  logic signed [IN_WIDTH:0] ext, sum, rnd;
  logic [OUT_WIDTH-1:0]     qval;

  assign ext = {FIR_output[IN_WIDTH-1], FIR_output};
  assign sum = ext + RND;
  assign rnd = sum >>> SHIFT;

`ifdef FIR_QUANT_SAT_EN
  localparam logic signed [IN_WIDTH:0] MAXV =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] MINV =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic sat;
  logic [15:0] sat_q, sat_d;

  assign sat  = (rnd > MAXV) || (rnd < MINV);
  assign qval = !sat ? rnd[OUT_WIDTH-1:0] :
                rnd[IN_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                {1'b0, {(OUT_WIDTH-1){1'b1}}};

  // Saturation counter: clear wins, then count up to all-ones
  always_comb begin
    sat_d = sat_q;
    if (clr_stats)
      sat_d = '0;
    else if (push && sat && sat_q != 16'hFFFF)
      sat_d = sat_q + 16'd1;
  end

  // Saturation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= '0;
    else     sat_q <= sat_d;
  end

  assign sat_count = sat_q;
`else
  assign qval      = rnd[OUT_WIDTH-1:0];
  assign sat_count = '0;
`endif

  assign in_ready = (cnt_q != FULL);
  assign push     = output_valid && in_ready;
  assign pop      = q_valid_q && q_ready;
  assign q_valid  = q_valid_q;
  assign q_data   = q_data_q;
  assign overrun  = ovr_q;

  // Next pointers, occupancy, head word and sticky overrun
  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    q_data_d = q_data_q;
    if (cnt_d != '0)
      q_data_d = (push && rd_d == wr_q) ? qval : mem_q[rd_d];
    ovr_d = ovr_q;
    if (clr_stats)
      ovr_d = 1'b0;
    else if (output_valid && !in_ready)
      ovr_d = 1'b1;
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= qval;
  end

  // FIFO control and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      q_data_q  <= '0;
      q_valid_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      q_data_q  <= q_data_d;
      q_valid_q <= (cnt_d != '0);
      ovr_q     <= ovr_d;
    end
  end

endmodule

// File: tb/tb_fir_output_quantizer.sv
// Testbench for fir_output_quantizer: directed cases plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_fir_output_quantizer;

  localparam int IW = 38;
  localparam int OW = 16;
  localparam int SH = 15;
  localparam int DP = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic [IW-1:0] FIR_output = '0;
  logic          output_valid = 0;
  logic          in_ready;
  logic [OW-1:0] q_data;
  logic          q_valid;
  logic          q_ready = 0;
  logic [15:0]   sat_count;
  logic          overrun;
  logic          clr_stats = 0;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  fir_output_quantizer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DEPTH(DP)
  ) dut (
    .clk(clk), .rst(rst),
    .FIR_output(FIR_output), .output_valid(output_valid),
    .in_ready(in_ready), .q_data(q_data), .q_valid(q_valid),
    .q_ready(q_ready), .sat_count(sat_count),
    .overrun(overrun), .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference quantizer: floor((v + 2^(SH-1)) / 2^SH), then clamp or wrap
  function automatic logic [OW-1:0] quant(input logic [IW-1:0] x,
                                          output bit s);
    longint v, r;
    v = $signed(x);
    r = (v + (64'sd1 <<< (SH-1))) >>> SH;
    s = 0;
`ifdef FIR_QUANT_SAT_EN
    if (r > 32767) begin r = 32767; s = 1; end
    if (r < -32768) begin r = -32768; s = 1; end
`endif
    return r[OW-1:0];
  endfunction

  logic [OW-1:0] mq[$];
  logic [OW-1:0] m_data = '0;
  int            m_sat = 0;
  bit            m_ovr = 0;

  // Model state: advances on each clock edge, cleared by reset
  always @(posedge clk or posedge rst) begin
    bit s, acc, pp;
    logic [OW-1:0] v;
    if (rst) begin
      mq.delete();
      m_data = '0;
      m_sat = 0;
      m_ovr = 0;
    end else begin
      acc = output_valid && (mq.size() < DP);
      pp  = (mq.size() > 0) && q_ready;
      v = quant(FIR_output, s);
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(v);
      if (clr_stats) begin
        m_sat = 0;
        m_ovr = 0;
      end else begin
        if (acc && s && m_sat != 65535) m_sat++;
        if (output_valid && !acc) m_ovr = 1;
      end
      if (mq.size() > 0) m_data = mq[0];
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    chk("q_valid", q_valid, mq.size() > 0);
    chk("q_data", q_data, m_data);
    chk("in_ready", in_ready, mq.size() < DP);
    chk("sat_count", sat_count, m_sat);
    chk("overrun", overrun, m_ovr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint v);
    FIR_output = IW'(v);
    output_valid = 1;
    tick();
    output_valid = 0;
  endtask

  initial begin
    longint big;
    big = 64'sd1 <<< 31;
    #1;
    chk("rst_q_valid", q_valid, 0);
    chk("rst_q_data", q_data, 0);
    chk("rst_sat", sat_count, 0);
    tick();
    rst = 0;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_overrun", overrun, 0);

    q_ready = 1;
    send(16384);  chk("rnd_16384", q_data, 16'h0001);
    chk("lat_valid", q_valid, 1);
    send(16383);  chk("rnd_16383", q_data, 16'h0000);
    send(-16384); chk("rnd_m16384", q_data, 16'h0000);
    send(-16385); chk("rnd_m16385", q_data, 16'hFFFF);
    tick();
    chk("drain_valid", q_valid, 0);
    chk("hold_data", q_data, 16'hFFFF);

`ifdef FIR_QUANT_SAT_EN
    send(big);  chk("sat_pos", q_data, 16'h7FFF);
    chk("sat_cnt1", sat_count, 1);
    send(-big); chk("sat_neg", q_data, 16'h8000);
    chk("sat_cnt2", sat_count, 2);
`else
    send(big);  chk("wrap_pos", q_data, 16'h0000);
    send(-big); chk("wrap_neg", q_data, 16'h0000);
    chk("wrap_cnt", sat_count, 0);
`endif
    tick();

    q_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      send(32768 * k);
      if (k == 4) chk("full_in_ready", in_ready, 0);
    end
    chk("overrun_set", overrun, 1);
    q_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_order", q_data, k);
      tick();
    end
    chk("drain_empty", q_valid, 0);
    clr_stats = 1;
    tick();
    clr_stats = 0;
    chk("clr_overrun", overrun, 0);

    q_ready = 0;
    send(32768 * 7);
    send(32768 * 8);
    q_ready = 1;
    send(32768 * 9);
    chk("pp_head", q_data, 8);
    chk("pp_valid", q_valid, 1);
    tick();
    chk("pp_next", q_data, 9);
    tick();
    chk("pp_empty", q_valid, 0);

    q_ready = 0;
    send(32768 * 3);
    send(32768 * 5);
    send(32768 * 6);
    #3 rst = 1;
    #1;
    chk("arst_valid", q_valid, 0);
    chk("arst_data", q_data, 0);
    tick();
    rst = 0;
    q_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", q_valid, 0);
    end

    clr_stats = 1;
    send(big);
    clr_stats = 0;
    chk("clr_sat", sat_count, 0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      longint r;
      r = longint'({$urandom, $urandom});
      r = r >>> $urandom_range(26, 44);
      FIR_output = IW'(r);
      output_valid = ($urandom_range(0, 1) == 1);
      q_ready = ($urandom_range(0, 2) != 0);
      clr_stats = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;
    output_valid = 0;
    clr_stats = 0;
    tick();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
